fpdiv_sched: RTL
================

Name: fpdiv_sched

Overview:
- Time-shares one combinational single-precision divider (`fpdiv`, result = A/B) among NUM_REQ requesters.
- Per-requester valid/ready request ports; round-robin grant.
- Operands are registered toward the divider, which is treated as a DIV_LAT-cycle multicycle path.
- The result is captured and returned on one shared response channel, tagged with the requester ID.
- Sits between the FP issue logic and the `fpdiv` instance; the top level wires div_a/div_b/div_result to `fpdiv`.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DIV_LAT, 2, cycles the divider inputs are held stable before result capture (>=1)
- ID_W, 2, width of rsp_id; must be >= clog2(NUM_REQ)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a  in  32*NUM_REQ  dividend, IEEE-754 single; requester i at [32i+31:32i]
- req_b  in  32*NUM_REQ  divisor, same packing
- div_a  out  32  registered dividend to `fpdiv`
- div_b  out  32  registered divisor to `fpdiv`
- div_result  in  32  `fpdiv` quotient
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  index of the requester that issued the operation
- rsp_data  out  32  quotient
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0, wait counter=0.
  - div_a=div_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - req_ready=0 while reset is asserted.
  - Reset mid-operation aborts the operation; the in-flight result is discarded, no response.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready is combinational: bit g=1 for g = first i with req_valid[i], searching from rr_ptr upward with wrap.
  - Handshake at the clock edge where req_valid[g] && req_ready[g]:
    - div_a<=req_a[g], div_b<=req_b[g], rsp_id<=g.
    - rr_ptr<=(g+1) mod NUM_REQ.
    - cnt<=DIV_LAT-1; state<=WAIT.
  - No valid requests: stay in IDLE, req_ready=0.
- WAIT:
  - req_ready=0; div_a/div_b held stable.
  - cnt decrements each cycle.
  - When cnt==0: rsp_data<=div_result, rsp_valid<=1, state<=RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_valid && rsp_ready; then rsp_valid<=0, state<=IDLE.
  - req_ready=0 in RESP; a new grant can occur in the first IDLE cycle after the response handshake.
- Latency: accept edge = cycle 0; rsp_valid=1 from cycle DIV_LAT+1.
  - Throughput with rsp_ready held high: one operation per DIV_LAT+2 cycles.
- Fairness: a continuously requesting input is granted within NUM_REQ grants.
- Requester obligation: req_a/req_b need to be stable only in the accept cycle; the block never samples them afterwards.
- Requester withdrawing req_valid before a grant is legal; nothing is latched.
- div_result is sampled only in the last WAIT cycle; its value at any other time is ignored.

Optional Feature:
- Macro: FPDIV_SCHED_EXC_EN.
- Defined:
  - Adds output rsp_exc [1:0] = {nan, dz}; reset 0.
  - Classification at accept:
    - NaN case: either operand is NaN, or 0/0, or inf/inf. rsp_data=32'h7FC00000, rsp_exc=2'b10.
    - Divide-by-zero: B=±0 and A is finite non-zero. rsp_data={sA^sB, 8'hFF, 23'h0}, rsp_exc=2'b01.
  - Exceptional operations bypass WAIT and go directly to RESP; rsp_valid is set at cycle 1.
  - rsp_exc=0 for normal operations.
- Undefined: the port is absent; all operands go through the divider with the standard latency.

Test Plan:
- Single op, requester 0, A=32'h3F28F5C3 (0.66), B=32'h3F028F5C (0.51), rsp_ready=1, DIV_LAT=2:
  - rsp_valid first high at cycle 3.
  - rsp_id=0; rsp_data within 1e-6 of 1.294118.
  - busy high in cycles 1..3.
- All 4 requesters valid continuously, each with distinct A (1.0, 2.0, 3.0, 4.0), B=2.0:
  - Grants in order 0,1,2,3,0.
  - Responses 0.5, 1.0, 1.5, 2.0 carry matching rsp_id.
- Backpressure: rsp_ready=0 for 5 cycles during RESP:
  - rsp_valid/rsp_data/rsp_id are held stable.
  - req_ready stays 0.
  - Requester 1 (valid throughout) is granted in the first IDLE cycle after the handshake.
- Reset: rst_n low during WAIT:
  - All outputs are immediately 0.
  - After release, rsp_valid stays 0 with no requests; the next request starts from rr_ptr=0.
- Random: 100 random operand pairs from requesters chosen at random:
  - Every rsp_data matches the IEEE quotient within 1e-6 relative error.
  - The response count per ID equals the accept count.
- With FPDIV_SCHED_EXC_EN:
  - A=32'h3F800000, B=32'h80000000 -> rsp_data=32'hFF800000, rsp_exc=01, rsp_valid at cycle 1.
  - A=0, B=0 -> rsp_data=32'h7FC00000, rsp_exc=10.

Source files
------------

// File: rtl/fpdiv_sched.sv
// rtl/fpdiv_sched.sv - round-robin scheduler sharing one multicycle fpdiv
//
// Purpose: arbitrates NUM_REQ valid/ready requesters onto one combinational
// single-precision divider (result = A/B). The operands are registered toward the
// divider and held for DIV_LAT cycles. The quotient is then returned on a single
// response channel, tagged with the requester index.
//
// Optional feature macro: FPDIV_SCHED_EXC_EN
//   When this macro is defined, the block adds rsp_exc[1:0] = {nan, dz}.
//   NaN-class and divide-by-zero operations bypass the divider and respond one
//   cycle after accept.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_a, req_b          packed operands, requester i at [32i+31:32i]
//   div_a, div_b          registered operands to fpdiv
//   div_result            fpdiv quotient
//   rsp_valid/rsp_ready   shared response handshake
//   rsp_id, rsp_data      requester index and quotient
//   busy                  high whenever the FSM is not IDLE
//   rsp_exc               {nan, dz} (FPDIV_SCHED_EXC_EN only)

module fpdiv_sched #(
  parameter int NUM_REQ = 4,
  parameter int DIV_LAT = 2,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [31:0]            div_a,
  output logic [31:0]            div_b,
  input  logic [31:0]            div_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_data,
  output logic                   busy
`ifdef FPDIV_SCHED_EXC_EN
  ,
  output logic [1:0]             rsp_exc
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       div_a_q, div_a_d;
  logic [31:0]       div_b_q, div_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              busy_q, busy_d;
`ifdef FPDIV_SCHED_EXC_EN
  logic [1:0]        rsp_exc_q, rsp_exc_d;
`endif

  logic              found;
  logic [PTR_W-1:0]  gnt_idx;
  logic [31:0]       sel_a, sel_b;

  // The round-robin search starts at rr_ptr and wraps around, and the first
  // requester with valid set wins the grant.
  always_comb begin
    int unsigned idx;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
  end

  assign sel_a = req_a[32*gnt_idx +: 32];
  assign sel_b = req_b[32*gnt_idx +: 32];

`ifdef FPDIV_SCHED_EXC_EN
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, exc_nan, exc_dz;
  always_comb begin
    a_nan   = (sel_a[30:23] == 8'hFF) && (sel_a[22:0] != 23'h0);
    b_nan   = (sel_b[30:23] == 8'hFF) && (sel_b[22:0] != 23'h0);
    a_inf   = (sel_a[30:23] == 8'hFF) && (sel_a[22:0] == 23'h0);
    b_inf   = (sel_b[30:23] == 8'hFF) && (sel_b[22:0] == 23'h0);
    a_zero  = (sel_a[30:0] == 31'h0);
    b_zero  = (sel_b[30:0] == 31'h0);
    exc_nan = a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
    // Subnormal dividends count as finite non-zero values here.
    exc_dz  = b_zero && !a_zero && !a_inf && !a_nan;
  end
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    div_a_d     = div_a_q;
    div_b_d     = div_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
`ifdef FPDIV_SCHED_EXC_EN
    rsp_exc_d   = rsp_exc_q;
`endif
    req_ready   = '0;

    case (state_q)
      S_IDLE: begin
        // The ready output is combinational, so the handshake completes whenever
        // any requester is valid.
        if (found && rst_n) begin
          req_ready[gnt_idx] = 1'b1;
          div_a_d  = sel_a;
          div_b_d  = sel_b;
          rsp_id_d = ID_W'(gnt_idx);
          rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
          cnt_d    = CNT_W'(DIV_LAT - 1);
          state_d  = S_WAIT;
`ifdef FPDIV_SCHED_EXC_EN
          rsp_exc_d = 2'b00;
          if (exc_nan) begin
            rsp_data_d  = 32'h7FC0_0000;
            rsp_exc_d   = 2'b10;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else if (exc_dz) begin
            rsp_data_d  = {sel_a[31] ^ sel_b[31], 8'hFF, 23'h0};
            rsp_exc_d   = 2'b01;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end
`endif
        end
      end
      S_WAIT: begin
        // The divider inputs have been stable for DIV_LAT cycles when cnt reaches 0.
        if (cnt_q == '0) begin
          rsp_data_d  = div_result;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
`ifdef FPDIV_SCHED_EXC_EN
      rsp_exc_q   <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      div_a_q     <= div_a_d;
      div_b_q     <= div_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
`ifdef FPDIV_SCHED_EXC_EN
      rsp_exc_q   <= rsp_exc_d;
`endif
    end
  end

  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;
`ifdef FPDIV_SCHED_EXC_EN
  assign rsp_exc   = rsp_exc_q;
`endif

endmodule
